// File: rtl/lbus_axi_pkg.sv
// lbus_axi_pkg: packet-filter FSM state encoding and tkeep byte-count helper.
package lbus_axi_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, DISCARD} state_t;
  function automatic logic [6:0] popcount(input logic [63:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) c = c + 7'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/axis_skid_buf.sv
// axis_skid_buf: 2-entry registered buffer, full throughput, accepts unless both entries hold data.
module axis_skid_buf #(
  parameter int W = 8
) (
  input  logic         sys_clk,
  input  logic         sys_reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         full,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic [W-1:0] mem [2];
  logic wp, rp, push, pop;
  logic [1:0] cnt;
  assign full = cnt[1];
  assign out_valid = cnt != 2'd0;
  assign out_data = mem[rp];
  assign push = in_valid && !full;
  assign pop = out_valid && out_ready;
  always_ff @(posedge sys_clk or posedge sys_reset)
    if (sys_reset) begin
      mem <= '{default: '0};
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) mem[wp] <= in_data;
      wp <= wp ^ push;
      rp <= rp ^ pop;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
endmodule

// File: rtl/axis_rx_len_filter.sv
// axis_rx_len_filter: marks runts, truncates oversize packets and reports packet length on tlast.
// Optional packet/runt/truncation counters via AXIS_RX_LEN_STATS_EN.
module axis_rx_len_filter
  import lbus_axi_pkg::*;
#(
  parameter int TDATA_BYTES   = 8,
  parameter int MAX_PKT_BYTES = 9600,
  parameter int MIN_PKT_BYTES = 64,
  parameter int LEN_WIDTH     = 16
) (
  input  logic                     sys_clk,
  input  logic                     sys_reset,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [8*TDATA_BYTES-1:0] s_axis_tdata,
  input  logic [TDATA_BYTES-1:0]   s_axis_tkeep,
  input  logic                     s_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [8*TDATA_BYTES-1:0] m_axis_tdata,
  output logic [TDATA_BYTES-1:0]   m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tuser,
  output logic [LEN_WIDTH-1:0]     m_pkt_len
`ifdef AXIS_RX_LEN_STATS_EN
  ,
  output logic [31:0]              stat_pkts,
  output logic [31:0]              stat_runts,
  output logic [31:0]              stat_trunc
`endif
);
  localparam int W = 8*TDATA_BYTES + TDATA_BYTES + 2 + LEN_WIDTH;
  localparam logic [LEN_WIDTH-1:0] MAX_L = LEN_WIDTH'(MAX_PKT_BYTES);
  localparam logic [LEN_WIDTH-1:0] MIN_L = LEN_WIDTH'(MIN_PKT_BYTES);
  state_t state, state_n;
  logic [LEN_WIDTH-1:0] cur_len, cur_len_n, run_len;
  logic [LEN_WIDTH:0] sum;
  logic en, full, acc, push, exceeds, o_last, o_user;
  always_comb begin
    sum = {1'b0, cur_len} + (LEN_WIDTH+1)'(popcount(64'(s_axis_tkeep)));
    run_len = sum[LEN_WIDTH] ? {LEN_WIDTH{1'b1}} : sum[LEN_WIDTH-1:0];
    exceeds = run_len > MAX_L;
    s_axis_tready = en && (state == DISCARD || !full);
    acc = s_axis_tvalid && s_axis_tready;
    push = acc && state != DISCARD;
    o_last = s_axis_tlast || exceeds;
    o_user = exceeds || (s_axis_tlast && run_len < MIN_L);
    state_n = !acc ? state : s_axis_tlast ? IDLE : (state == DISCARD || exceeds) ? DISCARD : ACTIVE;
    cur_len_n = !acc ? cur_len : (state == DISCARD || o_last) ? '0 : run_len;
  end
  // en holds tready low until the first clock edge after reset releases
  always_ff @(posedge sys_clk or posedge sys_reset)
    if (sys_reset) begin
      en <= 1'b0;
      state <= IDLE;
      cur_len <= '0;
    end else begin
      en <= 1'b1;
      state <= state_n;
      cur_len <= cur_len_n;
    end
  axis_skid_buf #(.W(W)) u_skid (
    .sys_clk  (sys_clk),
    .sys_reset(sys_reset),
    .in_valid (push),
    .in_data  ({s_axis_tdata, s_axis_tkeep, o_last, o_user, o_last ? run_len : {LEN_WIDTH{1'b0}}}),
    .full     (full),
    .out_valid(m_axis_tvalid),
    .out_ready(m_axis_tready),
    .out_data ({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, m_pkt_len})
  );
`ifdef AXIS_RX_LEN_STATS_EN
  logic fin;
  assign fin = m_axis_tvalid && m_axis_tready && m_axis_tlast;
  always_ff @(posedge sys_clk or posedge sys_reset)
    if (sys_reset) begin
      stat_pkts <= '0;
      stat_runts <= '0;
      stat_trunc <= '0;
    end else if (fin) begin
      stat_pkts <= stat_pkts + 32'd1;
      stat_runts <= stat_runts + 32'(m_axis_tuser && m_pkt_len < MIN_L);
      stat_trunc <= stat_trunc + 32'(m_axis_tuser && m_pkt_len >= MIN_L);
    end
`endif
endmodule

// File: tb/tb_axis_rx_len_filter.sv
// tb_axis_rx_len_filter: directed and random packets against a length-filter reference model.
module tb_axis_rx_len_filter;
  localparam int MAXB = 128;
  localparam int MINB = 64;
  logic sys_clk, sys_reset;
  logic s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [63:0] s_axis_tdata;
  logic [7:0] s_axis_tkeep;
  logic m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
  logic [63:0] m_axis_tdata;
  logic [7:0] m_axis_tkeep;
  logic [15:0] m_pkt_len;
`ifdef AXIS_RX_LEN_STATS_EN
  logic [31:0] stat_pkts, stat_runts, stat_trunc;
`endif
  axis_rx_len_filter #(.TDATA_BYTES(8), .MAX_PKT_BYTES(MAXB), .MIN_PKT_BYTES(MINB), .LEN_WIDTH(16)) dut (
    .sys_clk      (sys_clk),
    .sys_reset    (sys_reset),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tlast (s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser),
    .m_pkt_len    (m_pkt_len)
`ifdef AXIS_RX_LEN_STATS_EN
    ,
    .stat_pkts    (stat_pkts),
    .stat_runts   (stat_runts),
    .stat_trunc   (stat_trunc)
`endif
  );
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  int vec = 0;
  int err = 0;
  int nout = 0;
  int mst = 0;
  int mlen = 0;
  logic rnd_rdy = 1'b0;
  logic lat_chk = 1'b0;
  logic last_acc = 1'b0;
  logic [89:0] q[$];
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // one clock: check the output at negedge, then advance to just after posedge
  task automatic tick(output logic acc);
    @(negedge sys_clk);
    if (lat_chk && last_acc) chk("latency", 128'(m_axis_tvalid), 128'(1));
    if (m_axis_tvalid) begin
      chk("q_nonempty", 128'(q.size() != 0), 128'(1));
      if (q.size() != 0) begin
        chk("beat", 128'({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, m_pkt_len}), 128'(q[0]));
        if (m_axis_tready) begin
          void'(q.pop_front());
          nout++;
        end
      end
    end
    acc = s_axis_tvalid && s_axis_tready;
    @(posedge sys_clk);
    #1;
    last_acc = acc;
    m_axis_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask
  task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l);
    logic a;
    logic ol, ou;
    s_axis_tdata = d;
    s_axis_tkeep = k;
    s_axis_tlast = l;
    s_axis_tvalid = 1'b1;
    a = 1'b0;
    for (int n = 0; n < 100 && !a; n++) tick(a);
    chk("accept", 128'(a), 128'(1));
    if (a) begin
      if (mst == 2) begin
        if (l) mst = 0;
      end else begin
        mlen = (mlen + $countones(k) > 65535) ? 65535 : mlen + $countones(k);
        ol = l || mlen > MAXB;
        ou = mlen > MAXB || (l && mlen < MINB);
        q.push_back({d, k, ol, ou, 16'(ol ? mlen : 0)});
        mst = l ? 0 : (mlen > MAXB) ? 2 : 1;
        if (ol) mlen = 0;
      end
    end
  endtask
  task automatic pkt(input int beats, input logic [7:0] last_keep, input logic rnd_keep);
    for (int b = 0; b < beats; b++)
      send({$urandom, $urandom}, (b == beats - 1) ? last_keep : (rnd_keep && $urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hff, b == beats - 1);
  endtask
  task automatic drain();
    logic a;
    s_axis_tvalid = 1'b0;
    for (int n = 0; n < 300 && q.size() != 0; n++) tick(a);
    chk("drain", 128'(q.size()), 128'(0));
    tick(a);
    tick(a);
  endtask
  initial begin
    logic a;
    int n0;
    sys_reset = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    s_axis_tlast = 1'b0;
    m_axis_tready = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst_tready", 128'(s_axis_tready), 128'(0));
    chk("rst_tvalid", 128'(m_axis_tvalid), 128'(0));
    chk("rst_payload", 128'({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, m_pkt_len}), 128'(0));
    @(negedge sys_clk);
    sys_reset = 1'b0;
    @(posedge sys_clk);
    #1;
    chk("tready_rise", 128'(s_axis_tready), 128'(1));
    lat_chk = 1'b1;
    repeat (3) pkt(8, 8'hff, 1'b0);
    lat_chk = 1'b0;
    drain();
    pkt(5, 8'hff, 1'b0);
    drain();
    pkt(9, 8'h07, 1'b0);
    drain();
    n0 = nout;
    pkt(25, 8'hff, 1'b0);
    drain();
    chk("trunc_beats", 128'(nout - n0), 128'(17));
    pkt(8, 8'hff, 1'b0);
    pkt(17, 8'hff, 1'b0);
    pkt(8, 8'hff, 1'b0);
    pkt(9, 8'h00, 1'b0);
    drain();
    rnd_rdy = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      if ($urandom_range(0, 7) == 0) begin
        s_axis_tvalid = 1'b0;
        tick(a);
      end
      pkt($urandom_range(1, 20), 8'($urandom), 1'b1);
    end
    rnd_rdy = 1'b0;
    drain();
    for (int b = 0; b < 3; b++) send(64'hA5A5_0000_0000_0001 + 64'(b), 8'hff, 1'b0);
    s_axis_tdata = 64'hDEAD_BEEF_0000_0004;
    s_axis_tlast = 1'b0;
    s_axis_tvalid = 1'b1;
    #2 sys_reset = 1'b1;
    #1;
    chk("mid_rst_tvalid", 128'(m_axis_tvalid), 128'(0));
    chk("mid_rst_payload", 128'({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, m_pkt_len}), 128'(0));
    chk("mid_rst_tready", 128'(s_axis_tready), 128'(0));
`ifdef AXIS_RX_LEN_STATS_EN
    chk("stat_pkts_rst", 128'(stat_pkts), 128'(0));
`endif
    s_axis_tvalid = 1'b0;
    q.delete();
    mst = 0;
    mlen = 0;
    @(negedge sys_clk);
    sys_reset = 1'b0;
    @(posedge sys_clk);
    #1;
    chk("tready_rise2", 128'(s_axis_tready), 128'(1));
    pkt(8, 8'hff, 1'b0);
    drain();
`ifdef AXIS_RX_LEN_STATS_EN
    chk("stat_pkts_one", 128'(stat_pkts), 128'(1));
    chk("stat_runts_zero", 128'(stat_runts), 128'(0));
    chk("stat_trunc_zero", 128'(stat_trunc), 128'(0));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
